// File: rtl/row_readout_buffer.sv
// Two-bank ping-pong row buffer: captures a full (optionally Gray-decoded) pixel row
// and streams it out OUTPUT_BUS_WIDTH pixels per beat over a valid/ready handshake.
module row_readout_buffer #(
  parameter int PIXEL_ARRAY_WIDTH = 8,
  parameter int PIXEL_BITS        = 8,
  parameter int OUTPUT_BUS_WIDTH  = 2,
  parameter int GRAY_DECODE       = 1,
  parameter int ROW_TAG_BITS      = 4
) (
  input  logic                                   CLK,
  input  logic                                   RESET_N,
  input  logic                                   ROW_VALID,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] DATA_IN,
  output logic                                   ROW_READY,
  output logic                                   OUT_VALID,
  input  logic                                   OUT_READY,
  output logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0]  DATA_OUT,
  output logic                                   OUT_FIRST,
  output logic                                   OUT_LAST,
  output logic [ROW_TAG_BITS-1:0]                OUT_ROW,
  output logic                                   OUTPUT_EN,
  output logic                                   OVERFLOW,
  input  logic                                   CLEAR_OVERFLOW
);

  localparam int ROW_BITS  = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
  localparam int BUS_BITS  = OUTPUT_BUS_WIDTH * PIXEL_BITS;
  localparam int BEATS     = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
  localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

  generate
    if (PIXEL_ARRAY_WIDTH % OUTPUT_BUS_WIDTH != 0) begin : g_bad_bus_width
      $error("PIXEL_ARRAY_WIDTH must be a multiple of OUTPUT_BUS_WIDTH");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state;
  logic [ROW_BITS-1:0]     bank_data [2];
  logic [ROW_TAG_BITS-1:0] bank_tag  [2];
  logic [1:0]              bank_full;
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [BEAT_BITS-1:0]    beat;
  logic [ROW_TAG_BITS-1:0] tag_cnt;

  logic [ROW_BITS-1:0]     row_dec;
  logic                    capture;
  logic                    drop;
  logic                    xfer;
  logic                    last_xfer;
  logic [1:0]              full_nxt;
  logic                    rd_nxt;
  logic [BEAT_BITS-1:0]    beat_nxt;
  logic                    send_nxt;
  logic [ROW_BITS-1:0]     rd_row;
  logic [BUS_BITS-1:0]     beat_data;

  // Gray to binary per pixel: keep the MSB, each lower bit folds in the bit above it.
  always_comb begin
    row_dec = DATA_IN;
    if (GRAY_DECODE != 0) begin
      for (int unsigned p = 0; p < PIXEL_ARRAY_WIDTH; p++) begin
        for (int unsigned i = 1; i < PIXEL_BITS; i++) begin
          row_dec[p*PIXEL_BITS + PIXEL_BITS - 1 - i] =
            row_dec[p*PIXEL_BITS + PIXEL_BITS - i] ^ DATA_IN[p*PIXEL_BITS + PIXEL_BITS - 1 - i];
        end
      end
    end
  end

  always_comb begin
    capture   = ROW_VALID & ROW_READY;
    drop      = ROW_VALID & ~ROW_READY;
    xfer      = OUT_VALID & OUT_READY;
    last_xfer = xfer & (beat == LAST_BEAT);

    full_nxt = bank_full;
    if (last_xfer) full_nxt[rd_ptr] = 1'b0;
    if (capture)   full_nxt[wr_ptr] = 1'b1;

    rd_nxt = rd_ptr ^ last_xfer;
    if (last_xfer)  beat_nxt = '0;
    else if (xfer)  beat_nxt = beat + BEAT_BITS'(1);
    else            beat_nxt = beat;

    // Uses pre-edge flags so a row is only presented once its bank write has landed.
    send_nxt = 1'b0;
    case (state)
      IDLE:    send_nxt = bank_full[rd_ptr];
      SEND:    send_nxt = last_xfer ? bank_full[~rd_ptr] : 1'b1;
      default: send_nxt = 1'b0;
    endcase

    rd_row    = bank_data[rd_nxt];
    beat_data = rd_row[int'(beat_nxt)*BUS_BITS +: BUS_BITS];
  end

  always_ff @(posedge CLK) begin
    if (capture) begin
      bank_data[wr_ptr] <= row_dec;
      bank_tag[wr_ptr]  <= tag_cnt;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      bank_full <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      beat      <= '0;
      tag_cnt   <= '0;
      ROW_READY <= 1'b1;
      OUT_VALID <= 1'b0;
      OUT_FIRST <= 1'b0;
      OUT_LAST  <= 1'b0;
      OUT_ROW   <= '0;
      DATA_OUT  <= '0;
      OVERFLOW  <= 1'b0;
    end else begin
      state     <= send_nxt ? SEND : IDLE;
      bank_full <= full_nxt;
      wr_ptr    <= wr_ptr ^ capture;
      rd_ptr    <= rd_nxt;
      beat      <= beat_nxt;
      if (ROW_VALID) tag_cnt <= tag_cnt + ROW_TAG_BITS'(1);
      ROW_READY <= ~&full_nxt;
      OUT_VALID <= send_nxt;
      OUT_FIRST <= send_nxt & (beat_nxt == '0);
      OUT_LAST  <= send_nxt & (beat_nxt == LAST_BEAT);
      OUT_ROW   <= send_nxt ? bank_tag[rd_nxt] : '0;
      DATA_OUT  <= send_nxt ? beat_data : '0;
      if (drop)                OVERFLOW <= 1'b1;
      else if (CLEAR_OVERFLOW) OVERFLOW <= 1'b0;
    end
  end

  assign OUTPUT_EN = OUT_VALID;

endmodule
